// File: rtl/lmg_move_reader_pkg.sv
// lmg_move_reader_pkg: word geometry, slot helper and FSM states
// shared by the LMG move FIFO consumer and its slot picker.
package lmg_move_reader_pkg;

  localparam int MOVE_W  = 19;
  localparam int SLOTS   = 8;
  localparam int WORD_W  = 160;
  localparam int MASK_LO = 152;
  localparam int BODY_W  = MASK_LO;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_READ,
    ST_WAIT,
    ST_EMIT,
    ST_FIN
  } state_t;

  // idx 0 is slot 1, packed directly under the mask
  function automatic int slot_lo(input logic [2:0] idx);
    return MASK_LO - MOVE_W * (int'(idx) + 1);
  endfunction

endpackage

// File: rtl/lmg_slot_picker.sv
// lmg_slot_picker: priority encoder over the slot-valid mask.
// Ports: i_mask/i_word in; o_idx (0 = slot 1), o_any, o_move out.
module lmg_slot_picker
  import lmg_move_reader_pkg::*;
(
  input  logic [SLOTS-1:0]  i_mask,
  input  logic [BODY_W-1:0] i_word,
  output logic [2:0]        o_idx,
  output logic              o_any,
  output logic [MOVE_W-1:0] o_move
);

  logic [BODY_W-1:0] w_shift;

  // scan from slot 8 down so the lowest-numbered slot wins
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (i_mask[SLOTS-1-s]) begin
        o_idx = 3'(s);
        o_any = 1'b1;
      end
    end
  end

  assign w_shift = i_word >> slot_lo(o_idx);
  assign o_move  = w_shift[MOVE_W-1:0];

endmodule

// File: rtl/lmg_move_reader.sv
// lmg_move_reader: drains the LMG move FIFO after lmg_done and streams
// the packed moves out on mv_valid/mv_ready with count and done flag.
// Ports: clk, reset (async, low), start, lmg_done, fifo_empty,
// fifo_out in; rden out; mv_valid/mv_ready/mv_data stream;
// mv_count, drain_done out.
module lmg_move_reader
  import lmg_move_reader_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              lmg_done,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_out,
  output logic              rden,
  output logic              mv_valid,
  input  logic              mv_ready,
  output logic [MOVE_W-1:0] mv_data,
  output logic [CNT_W-1:0]  mv_count,
  output logic              drain_done
);

  state_t r_state;
  state_t w_next;

  logic [1:0]        r_wcnt;
  logic [SLOTS-1:0]  r_mask;
  logic [SLOTS-1:0]  w_nmask;
  logic [BODY_W-1:0] r_word;
  logic [BODY_W-1:0] w_nword;
  logic [2:0]        r_idx;
  logic [2:0]        w_idx;
  logic              w_any;
  logic [MOVE_W-1:0] w_move;
  logic [MOVE_W-1:0] r_mv_data;
  logic              r_mv_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;
  logic              w_latch;
  logic              w_fire;
  logic              w_emit;

  localparam logic [SLOTS-1:0] SLOT1 =
    {1'b1, {(SLOTS-1){1'b0}}};

  assign w_fire  = r_mv_valid & mv_ready;
  assign w_latch = (r_state == ST_WAIT) &&
                   (r_wcnt == 2'(RD_LAT));

  // picker looks at the mask/word the next cycle will hold,
  // so the move can be registered with no bubble
  always_comb begin
    w_nmask = r_mask;
    w_nword = r_word;
    if (w_latch) begin
      w_nmask = fifo_out[WORD_W-1:MASK_LO];
      w_nword = fifo_out[BODY_W-1:0];
    end else if (w_fire) begin
      w_nmask = r_mask & ~(SLOT1 >> r_idx);
    end
  end

  lmg_slot_picker u_pick (
    .i_mask (w_nmask),
    .i_word (w_nword),
    .o_idx  (w_idx),
    .o_any  (w_any),
    .o_move (w_move)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    rden   = 1'b0;
    unique case (r_state)
      ST_IDLE: if (start) w_next = ST_ARM;
      ST_ARM:  if (lmg_done) w_next = ST_READ;
      ST_READ: begin
        if (fifo_empty) begin
          w_next = ST_FIN;
        end else begin
          rden   = 1'b1;
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_latch)
          w_next = w_any ? ST_EMIT : ST_READ;
      end
      ST_EMIT: if (!w_any) w_next = ST_READ;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_emit = (w_next == ST_EMIT) && w_any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt     <= '0;
      r_mask     <= '0;
      r_word     <= '0;
      r_idx      <= '0;
      r_mv_valid <= 1'b0;
      r_mv_data  <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
    end else begin
      if (r_state == ST_READ)
        r_wcnt <= 2'd1;
      else if (r_state == ST_WAIT && !w_latch)
        r_wcnt <= r_wcnt + 2'd1;
      r_mask     <= w_nmask;
      r_word     <= w_nword;
      r_idx      <= w_idx;
      r_mv_valid <= w_emit;
      r_mv_data  <= w_emit ? w_move : '0;
      if (r_state == ST_IDLE && start) begin
        r_cnt  <= '0;
        r_done <= 1'b0;
      end else if (w_fire && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == ST_READ && fifo_empty)
        r_done <= 1'b1;
    end
  end

  assign mv_valid   = r_mv_valid;
  assign mv_data    = r_mv_data;
  assign mv_count   = r_cnt;
  assign drain_done = r_done;

endmodule

// File: tb/tb_lmg_move_reader.sv
// tb_lmg_move_reader: two DUTs (RD_LAT 1 and 2) share one stimulus;
// each sees its own FIFO read pointer over a common word list.
module tb_lmg_move_reader;

  localparam int N = 2;
  localparam logic [159:0] JUNK =
    {8'hFF, {8{19'h5A5A5}}};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic lmg_done = 1'b0;
  logic mv_ready = 1'b0;

  logic         fifo_empty [N];
  logic [159:0] fifo_out   [N];
  logic         rden       [N];
  logic         mv_valid   [N];
  logic         drain_done [N];
  logic [18:0]  mv_data    [N];
  logic [7:0]   mv_count   [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    lmg_move_reader #(
      .RD_LAT(g + 1),
      .CNT_W (8)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .lmg_done   (lmg_done),
      .fifo_empty (fifo_empty[g]),
      .fifo_out   (fifo_out[g]),
      .rden       (rden[g]),
      .mv_valid   (mv_valid[g]),
      .mv_ready   (mv_ready),
      .mv_data    (mv_data[g]),
      .mv_count   (mv_count[g]),
      .drain_done (drain_done[g])
    );
  end

  logic [159:0] src[$];
  logic [18:0]  exp_q[$];
  logic [18:0]  recv[N][$];
  int           tst[N][$];
  int           rp[N];
  int           rd_cnt[N];
  int           viol[N];
  int           cyc = 0;
  logic         v1[N];
  logic         v2[N];
  logic [159:0] d1[N];
  logic [159:0] d2[N];
  int checks = 0;
  int failures = 0;

  // FIFO model: data is only meaningful exactly RD_LAT cycles
  // after rden; otherwise the bus carries junk
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < N; k++) begin
      v1[k] <= rden[k];
      d1[k] <= (rp[k] < src.size()) ? src[rp[k]] : JUNK;
      v2[k] <= v1[k];
      d2[k] <= d1[k];
      if (rden[k]) begin
        if (fifo_empty[k]) viol[k] <= viol[k] + 1;
        rp[k]     <= rp[k] + 1;
        rd_cnt[k] <= rd_cnt[k] + 1;
      end
      fifo_empty[k] <=
        (rp[k] + int'(rden[k])) >= src.size();
      if (mv_valid[k] && mv_ready) begin
        recv[k].push_back(mv_data[k]);
        tst[k].push_back(cyc);
      end
    end
  end

  always_comb begin
    fifo_out[0] = v1[0] ? d1[0] : JUNK;
    fifo_out[1] = v2[1] ? d2[1] : JUNK;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  function automatic logic [159:0] mk_word(
      input logic [7:0] m, input bit seq, input int base);
    logic [159:0] w;
    w = '0;
    w[159:152] = m;
    for (int s = 1; s <= 8; s++)
      w[151-19*(s-1) -: 19] =
        seq ? 19'(base + s - 1) : 19'($urandom);
    return w;
  endfunction

  // reference: slots in order 1..8, words in FIFO order
  task automatic build_exp();
    logic [159:0] w;
    exp_q.delete();
    foreach (src[i]) begin
      w = src[i];
      for (int s = 1; s <= 8; s++)
        if (w[160-s])
          exp_q.push_back(w[151-19*(s-1) -: 19]);
    end
  endtask

  task automatic arm_fifo();
    for (int k = 0; k < N; k++) begin
      rp[k] = 0;
      rd_cnt[k] = 0;
      viol[k] = 0;
      fifo_empty[k] = (src.size() == 0);
      recv[k].delete();
      tst[k].delete();
    end
    build_exp();
  endtask

  task automatic start_pos();
    @(negedge clk);
    lmg_done = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag,
                           input bit rnd, input int budget);
    int n;
    n = 0;
    while (!(drain_done[0] && drain_done[1]) && n < budget) begin
      if (rnd) mv_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    mv_ready = 1'b1;
    chk({tag, "_timeout"}, 32'(n < budget), 1);
  endtask

  task automatic wait_recv0(input int cnt);
    int n;
    n = 0;
    while (recv[0].size() < cnt && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_moves", 32'(n < 200), 1);
  endtask

  task automatic check_pos(input string tag, input int exp_rd);
    int bad;
    int ec;
    ec = (exp_q.size() > 255) ? 255 : exp_q.size();
    for (int k = 0; k < N; k++) begin
      bad = 0;
      chk($sformatf("%s_len%0d", tag, k),
          recv[k].size(), exp_q.size());
      for (int i = 0; i < recv[k].size(); i++)
        if (i >= exp_q.size() || recv[k][i] !== exp_q[i])
          bad++;
      chk($sformatf("%s_order%0d", tag, k), bad, 0);
      chk($sformatf("%s_count%0d", tag, k),
          mv_count[k], ec);
      chk($sformatf("%s_rden%0d", tag, k), rd_cnt[k], exp_rd);
      chk($sformatf("%s_viol%0d", tag, k), viol[k], 0);
      chk($sformatf("%s_done%0d", tag, k), drain_done[k], 1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_rden%0d", tag, k), rden[k], 0);
      chk($sformatf("%s_valid%0d", tag, k), mv_valid[k], 0);
      chk($sformatf("%s_data%0d", tag, k), mv_data[k], 0);
      chk($sformatf("%s_count%0d", tag, k), mv_count[k], 0);
      chk($sformatf("%s_done%0d", tag, k), drain_done[k], 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;
    logic        sv[N];
    logic [18:0] sd[N];
    logic [7:0]  sc[N];
    int          sr[N];
    int          nw;

    src.delete();
    arm_fifo();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    mv_ready = 1'b1;

    // empty position
    src.delete();
    arm_fifo();
    start_pos();
    repeat (2) @(negedge clk);
    check_pos("empty", 0);

    // one full word, moves 1..8
    src.delete();
    src.push_back(mk_word(8'hFF, 1, 1));
    arm_fifo();
    start_pos();
    wait_done("full", 0, 100);
    check_pos("full", 1);
    for (int k = 0; k < N; k++)
      chk($sformatf("full_b2b%0d", k),
          (tst[k].size() == 8) ? tst[k][7] - tst[k][0] : -1,
          7);

    // sparse word then an all-zero-mask word
    src.delete();
    src.push_back(mk_word(8'b1010_0001, 0, 0));
    src.push_back(mk_word(8'h00, 0, 0));
    arm_fifo();
    start_pos();
    wait_done("sparse", 0, 100);
    check_pos("sparse", 2);

    // backpressure mid-word
    src.delete();
    src.push_back(mk_word(8'hFF, 0, 0));
    arm_fifo();
    start_pos();
    wait_recv0(3);
    mv_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      sv[k] = mv_valid[k];
      sd[k] = mv_data[k];
      sc[k] = mv_count[k];
      sr[k] = rd_cnt[k];
    end
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        chk($sformatf("bp_valid%0d", k), mv_valid[k], 1);
        chk($sformatf("bp_vstab%0d", k), mv_valid[k], sv[k]);
        chk($sformatf("bp_data%0d", k), mv_data[k], sd[k]);
        chk($sformatf("bp_count%0d", k), mv_count[k], sc[k]);
        chk($sformatf("bp_rden%0d", k), rd_cnt[k], sr[k]);
      end
    end
    mv_ready = 1'b1;
    wait_done("bp", 0, 100);
    check_pos("bp", 1);

    // multi-word; lmg_done drops and start pulses mid-drain
    src.delete();
    m = '0;
    while ($countones(m) < 4) m[$urandom_range(0, 7)] = 1'b1;
    src.push_back(mk_word(8'hFF, 0, 0));
    src.push_back(mk_word(8'hFF, 0, 0));
    src.push_back(mk_word(m, 0, 0));
    arm_fifo();
    start_pos();
    repeat (3) @(negedge clk);
    lmg_done = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("multi", 0, 200);
    check_pos("multi", 3);

    // reset mid-drain, then a fresh 2-move position
    src.delete();
    src.push_back(mk_word(8'hFF, 0, 0));
    src.push_back(mk_word(8'hFF, 0, 0));
    arm_fifo();
    start_pos();
    wait_recv0(3);
    reset = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    src.delete();
    src.push_back(mk_word(8'b0100_0010, 0, 0));
    arm_fifo();
    start_pos();
    wait_done("after_rst", 0, 100);
    check_pos("after_rst", 1);

    // randomized positions with random backpressure
    for (int r = 0; r < 6; r++) begin
      src.delete();
      nw = $urandom_range(0, 5);
      for (int i = 0; i < nw; i++)
        src.push_back(mk_word(8'($urandom), 0, 0));
      arm_fifo();
      start_pos();
      wait_done("rand", 1, 1000);
      check_pos($sformatf("rand%0d", r), nw);
    end

    // counter saturation: 264 moves
    src.delete();
    for (int i = 0; i < 33; i++)
      src.push_back(mk_word(8'hFF, 0, 0));
    arm_fifo();
    start_pos();
    wait_done("sat", 0, 2000);
    check_pos("sat", 33);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
